// File: rtl/operand_a_stage.sv
// Operand-A select stage: picks the ALU A operand (with EX/MEM forwarding),
// holds it in a one-entry valid/ready output register and counts stall cycles.
module operand_a_stage #(
    parameter int WIDTH     = 32,
    parameter int CONST_VAL = 4,
    parameter int REG_W     = 5,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       sel_operA,
    input  logic [WIDTH-1:0] input_number,
    input  logic [WIDTH-1:0] immediate_ext,
    input  logic [WIDTH-1:0] immediate_desp,
    input  logic [REG_W-1:0] src_reg,
    input  logic             fwd_ex_en,
    input  logic             fwd_mem_en,
    input  logic [REG_W-1:0] fwd_ex_reg,
    input  logic [REG_W-1:0] fwd_mem_reg,
    input  logic [WIDTH-1:0] fwd_ex_data,
    input  logic [WIDTH-1:0] fwd_mem_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] output_A,
    output logic [1:0]       fwd_hit,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [WIDTH-1:0] CONST_OPERAND = WIDTH'(CONST_VAL);
    localparam logic [1:0]       HIT_NONE      = 2'b00;
    localparam logic [1:0]       HIT_EX        = 2'b01;
    localparam logic [1:0]       HIT_MEM       = 2'b10;

    logic [WIDTH-1:0] operand_p0;
    logic [1:0]       hit_p0;
    logic             accept_p0;

    logic [WIDTH-1:0] operand_p1;
    logic [1:0]       hit_p1;
    logic             vld_p1;
    logic [CNT_W-1:0] stall_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Stage p0: combinational source select; register 0 never forwards (hard-wired zero)
    always_comb begin
        operand_p0 = input_number;
        hit_p0     = HIT_NONE;
        case (sel_operA)
            2'b00: begin
                if (src_reg != '0) begin
                    if (fwd_ex_en && (fwd_ex_reg == src_reg)) begin
                        operand_p0 = fwd_ex_data;
                        hit_p0     = HIT_EX;
                    end else if (fwd_mem_en && (fwd_mem_reg == src_reg)) begin
                        operand_p0 = fwd_mem_data;
                        hit_p0     = HIT_MEM;
                    end
                end
            end
            2'b01:   operand_p0 = CONST_OPERAND;
            2'b10:   operand_p0 = immediate_ext;
            2'b11:   operand_p0 = immediate_desp;
            default: operand_p0 = input_number;
        endcase
    end

    assign in_ready  = !vld_p1 || out_ready;
    assign accept_p0 = in_valid && in_ready && !flush;

    // Stage p1: output register; flush beats accept, accept beats drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand_p1 <= '0;
            hit_p1     <= HIT_NONE;
            vld_p1     <= 1'b0;
            stall_p1   <= '0;
        end else begin
            if (vld_p1 && !out_ready)
                stall_p1 <= sat_inc(stall_p1);
            if (flush) begin
                vld_p1 <= 1'b0;
                hit_p1 <= HIT_NONE;
            end else if (accept_p0) begin
                vld_p1     <= 1'b1;
                operand_p1 <= operand_p0;
                hit_p1     <= hit_p0;
            end else if (out_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign output_A  = operand_p1;
    assign fwd_hit   = hit_p1;
    assign stall_cnt = stall_p1;

endmodule

// File: tb/tb_operand_a_stage.sv
// Directed self-checking bench for operand_a_stage (default widths plus a
// CNT_W=2 instance for counter saturation).
module tb_operand_a_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  sel_operA;
    logic [31:0] input_number;
    logic [31:0] immediate_ext;
    logic [31:0] immediate_desp;
    logic [4:0]  src_reg;
    logic        fwd_ex_en;
    logic        fwd_mem_en;
    logic [4:0]  fwd_ex_reg;
    logic [4:0]  fwd_mem_reg;
    logic [31:0] fwd_ex_data;
    logic [31:0] fwd_mem_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] output_A;
    logic [1:0]  fwd_hit;
    logic [7:0]  stall_cnt;

    logic        s_in_ready;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [31:0] s_output_A;
    logic [1:0]  s_fwd_hit;
    logic [1:0]  s_stall_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    operand_a_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sel_operA(sel_operA), .input_number(input_number),
        .immediate_ext(immediate_ext), .immediate_desp(immediate_desp),
        .src_reg(src_reg), .fwd_ex_en(fwd_ex_en), .fwd_mem_en(fwd_mem_en),
        .fwd_ex_reg(fwd_ex_reg), .fwd_mem_reg(fwd_mem_reg),
        .fwd_ex_data(fwd_ex_data), .fwd_mem_data(fwd_mem_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .output_A(output_A), .fwd_hit(fwd_hit), .stall_cnt(stall_cnt)
    );

    operand_a_stage #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .sel_operA(sel_operA), .input_number(input_number),
        .immediate_ext(immediate_ext), .immediate_desp(immediate_desp),
        .src_reg(src_reg), .fwd_ex_en(fwd_ex_en), .fwd_mem_en(fwd_mem_en),
        .fwd_ex_reg(fwd_ex_reg), .fwd_mem_reg(fwd_mem_reg),
        .fwd_ex_data(fwd_ex_data), .fwd_mem_data(fwd_mem_data),
        .flush(flush), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .output_A(s_output_A), .fwd_hit(s_fwd_hit), .stall_cnt(s_stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; sel_operA = 2'b00; input_number = '0;
        immediate_ext = '0; immediate_desp = '0; src_reg = '0;
        fwd_ex_en = 1'b0; fwd_mem_en = 1'b0; fwd_ex_reg = '0; fwd_mem_reg = '0;
        fwd_ex_data = '0; fwd_mem_data = '0; flush = 1'b0;
        out_ready = 1'b1; s_out_ready = 1'b1;
        #3;
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid: got %0h expected 0", out_valid); end
        vec_cnt++; if (output_A !== 32'h0) begin err_cnt++; $display("FAIL reset_output_A: got %0h expected 0", output_A); end
        vec_cnt++; if (fwd_hit !== 2'b00) begin err_cnt++; $display("FAIL reset_fwd_hit: got %0h expected 0", fwd_hit); end
        vec_cnt++; if (stall_cnt !== 8'h0) begin err_cnt++; $display("FAIL reset_stall_cnt: got %0h expected 0", stall_cnt); end
        step(); step();
        rst_n = 1'b1;
        vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_in_ready: got %0h expected 1", in_ready); end
    endtask

    task automatic test_const();
        in_valid = 1'b1; sel_operA = 2'b01; out_ready = 1'b1;
        step();
        vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL const_out_valid: got %0h expected 1", out_valid); end
        vec_cnt++; if (output_A !== 32'h4) begin err_cnt++; $display("FAIL const_output_A: got %0h expected 4", output_A); end
        vec_cnt++; if (fwd_hit !== 2'b00) begin err_cnt++; $display("FAIL const_fwd_hit: got %0h expected 0", fwd_hit); end
        in_valid = 1'b0;
        step();
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL drain_out_valid: got %0h expected 0", out_valid); end
    endtask

    task automatic test_forwarding();
        in_valid = 1'b1; out_ready = 1'b1; sel_operA = 2'b00;
        src_reg = 5'd3; input_number = 32'h11;
        fwd_ex_en = 1'b1; fwd_ex_reg = 5'd3; fwd_ex_data = 32'hAA;
        fwd_mem_en = 1'b1; fwd_mem_reg = 5'd3; fwd_mem_data = 32'hBB;
        step();
        vec_cnt++; if (output_A !== 32'hAA) begin err_cnt++; $display("FAIL fwd_ex_data: got %0h expected aa", output_A); end
        vec_cnt++; if (fwd_hit !== 2'b01) begin err_cnt++; $display("FAIL fwd_ex_hit: got %0h expected 1", fwd_hit); end
        fwd_ex_en = 1'b0;
        step();
        vec_cnt++; if (output_A !== 32'hBB) begin err_cnt++; $display("FAIL fwd_mem_data: got %0h expected bb", output_A); end
        vec_cnt++; if (fwd_hit !== 2'b10) begin err_cnt++; $display("FAIL fwd_mem_hit: got %0h expected 2", fwd_hit); end
        fwd_ex_en = 1'b1; src_reg = 5'd0; fwd_ex_reg = 5'd0; fwd_mem_reg = 5'd0;
        step();
        vec_cnt++; if (output_A !== 32'h11) begin err_cnt++; $display("FAIL fwd_r0_data: got %0h expected 11", output_A); end
        vec_cnt++; if (fwd_hit !== 2'b00) begin err_cnt++; $display("FAIL fwd_r0_hit: got %0h expected 0", fwd_hit); end
        src_reg = 5'd5; fwd_ex_reg = 5'd3; fwd_mem_reg = 5'd4;
        step();
        vec_cnt++; if (output_A !== 32'h11) begin err_cnt++; $display("FAIL fwd_nomatch_data: got %0h expected 11", output_A); end
        vec_cnt++; if (fwd_hit !== 2'b00) begin err_cnt++; $display("FAIL fwd_nomatch_hit: got %0h expected 0", fwd_hit); end
        sel_operA = 2'b10; immediate_ext = 32'hCAFE; src_reg = 5'd3; fwd_ex_reg = 5'd3;
        step();
        vec_cnt++; if (output_A !== 32'hCAFE) begin err_cnt++; $display("FAIL imm_ignores_fwd_data: got %0h expected cafe", output_A); end
        vec_cnt++; if (fwd_hit !== 2'b00) begin err_cnt++; $display("FAIL imm_ignores_fwd_hit: got %0h expected 0", fwd_hit); end
        in_valid = 1'b0; fwd_ex_en = 1'b0; fwd_mem_en = 1'b0;
        step();
    endtask

    task automatic test_stall();
        in_valid = 1'b1; sel_operA = 2'b10; immediate_ext = 32'h1234; out_ready = 1'b1;
        step();
        vec_cnt++; if (output_A !== 32'h1234) begin err_cnt++; $display("FAIL stall_load: got %0h expected 1234", output_A); end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            immediate_ext = 32'hDEAD0000 + i;
            sel_operA = 2'(i);
            step();
            vec_cnt++; if (output_A !== 32'h1234) begin err_cnt++; $display("FAIL stall_hold_%0d: got %0h expected 1234", i, output_A); end
            vec_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL stall_in_ready_%0d: got %0h expected 0", i, in_ready); end
        end
        vec_cnt++; if (stall_cnt !== 8'd5) begin err_cnt++; $display("FAIL stall_cnt5: got %0d expected 5", stall_cnt); end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL stall_release_in_ready: got %0h expected 1", in_ready); end
        step();
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL stall_drain: got %0h expected 0", out_valid); end
        vec_cnt++; if (stall_cnt !== 8'd5) begin err_cnt++; $display("FAIL stall_cnt_kept: got %0d expected 5", stall_cnt); end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; out_ready = 1'b1; sel_operA = 2'b00; src_reg = 5'd7;
        fwd_ex_en = 1'b1; fwd_ex_reg = 5'd7; fwd_ex_data = 32'h77;
        step();
        vec_cnt++; if (fwd_hit !== 2'b01) begin err_cnt++; $display("FAIL flush_pre_hit: got %0h expected 1", fwd_hit); end
        out_ready = 1'b0; flush = 1'b1;
        step();
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_out_valid: got %0h expected 0", out_valid); end
        vec_cnt++; if (fwd_hit !== 2'b00) begin err_cnt++; $display("FAIL flush_fwd_hit: got %0h expected 0", fwd_hit); end
        vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL flush_in_ready: got %0h expected 1", in_ready); end
        vec_cnt++; if (stall_cnt !== 8'd6) begin err_cnt++; $display("FAIL flush_stall_cnt: got %0d expected 6", stall_cnt); end
        flush = 1'b0; in_valid = 1'b0; fwd_ex_en = 1'b0; out_ready = 1'b1;
        step();
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_dropped: got %0h expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; out_ready = 1'b1; sel_operA = 2'b11;
        for (int i = 1; i <= 4; i++) begin
            immediate_desp = 32'(i);
            step();
            vec_cnt++; if (output_A !== 32'(i)) begin err_cnt++; $display("FAIL b2b_data_%0d: got %0h expected %0h", i, output_A, i); end
            vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL b2b_valid_%0d: got %0h expected 1", i, out_valid); end
        end
        rst_n = 1'b0;
        #1;
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL async_rst_valid: got %0h expected 0", out_valid); end
        vec_cnt++; if (output_A !== 32'h0) begin err_cnt++; $display("FAIL async_rst_data: got %0h expected 0", output_A); end
        vec_cnt++; if (stall_cnt !== 8'h0) begin err_cnt++; $display("FAIL async_rst_stall: got %0d expected 0", stall_cnt); end
        #1 rst_n = 1'b1;
        immediate_desp = 32'h55;
        step();
        out_ready = 1'b0; in_valid = 1'b0;
        step();
        vec_cnt++; if (output_A !== 32'h55) begin err_cnt++; $display("FAIL midstall_held: got %0h expected 55", output_A); end
        rst_n = 1'b0;
        #1;
        vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL midstall_rst_valid: got %0h expected 0", out_valid); end
        #1 rst_n = 1'b1;
        vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL midstall_in_ready: got %0h expected 1", in_ready); end
        in_valid = 1'b1; sel_operA = 2'b01;
        step();
        vec_cnt++; if (output_A !== 32'h4) begin err_cnt++; $display("FAIL post_rst_accept: got %0h expected 4", output_A); end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
    endtask

    task automatic test_saturate();
        in_valid = 1'b1; sel_operA = 2'b01; out_ready = 1'b1; s_out_ready = 1'b1;
        step();
        in_valid = 1'b0; s_out_ready = 1'b0;
        vec_cnt++; if (s_stall_cnt !== 2'd0) begin err_cnt++; $display("FAIL sat_start: got %0d expected 0", s_stall_cnt); end
        for (int k = 1; k <= 6; k++) begin
            step();
            vec_cnt++;
            if (s_stall_cnt !== 2'((k < 3) ? k : 3)) begin
                err_cnt++; $display("FAIL sat_cnt_%0d: got %0d expected %0d", k, s_stall_cnt, (k < 3) ? k : 3);
            end
        end
        vec_cnt++; if (s_output_A !== 32'h4) begin err_cnt++; $display("FAIL sat_hold: got %0h expected 4", s_output_A); end
        s_out_ready = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_const();
        test_forwarding();
        test_stall();
        test_flush();
        test_back_to_back();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/operand_a_stage.md
OPERAND_A_STAGE -- requirements
Module: operand_a_stage

Interface
REQ-001 Parameter WIDTH, default 32, operand data width in bits.
REQ-002 Parameter CONST_VAL, default 4, constant driven when sel_operA = 2'b01.
REQ-003 Parameter REG_W, default 5, register-index width.
REQ-004 Parameter CNT_W, default 8, stall-counter width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  upstream presents an operand request.
REQ-008 in_ready  output  1  stage can accept a request this cycle.
REQ-009 sel_operA  input  2  source select: 00 input_number, 01 CONST_VAL, 10 immediate_ext, 11 immediate_desp.
REQ-010 input_number  input  WIDTH  register-file operand.
REQ-011 immediate_ext  input  WIDTH  sign/zero-extended immediate.
REQ-012 immediate_desp  input  WIDTH  shifted immediate.
REQ-013 src_reg  input  REG_W  register index of input_number.
REQ-014 fwd_ex_en, fwd_mem_en  input  1 each  forwarding source valid (EX stage, MEM stage).
REQ-015 fwd_ex_reg, fwd_mem_reg  input  REG_W each  destination register of each forwarding source.
REQ-016 fwd_ex_data, fwd_mem_data  input  WIDTH each  forwarded result values.
REQ-017 flush  input  1  discard held operand.
REQ-018 out_valid  output  1  output_A holds a valid operand.
REQ-019 out_ready  input  1  downstream accepts output_A this cycle.
REQ-020 output_A  output  WIDTH  registered selected operand.
REQ-021 fwd_hit  output  2  registered with output_A: 00 none, 01 EX forwarded, 10 MEM forwarded.
REQ-022 stall_cnt  output  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Function
REQ-023 Selection SHALL apply only when sel_operA=00: if fwd_ex_en and fwd_ex_reg==src_reg, use fwd_ex_data (fwd_hit=01); else if fwd_mem_en and fwd_mem_reg==src_reg, use fwd_mem_data (fwd_hit=10); else input_number (fwd_hit=00).
REQ-024 Forwarding SHALL be suppressed when src_reg==0; result is input_number, fwd_hit=00.
REQ-025 For sel_operA 01/10/11 the source SHALL be CONST_VAL (zero-extended/truncated to WIDTH), immediate_ext, immediate_desp respectively, fwd_hit=00, regardless of forwarding inputs.
REQ-026 in_ready SHALL be combinational: !out_valid || out_ready.
REQ-027 Accept occurs when in_valid && in_ready && !flush; selected value, fwd_hit and out_valid=1 SHALL be registered on that edge (latency 1 cycle).
REQ-028 When out_valid && out_ready and no accept, out_valid SHALL clear next edge.
REQ-029 When out_valid && !out_ready, output_A, fwd_hit and out_valid SHALL hold unchanged; inputs sampled later SHALL not alter them.
REQ-030 Simultaneous drain and accept (out_ready=1, in_valid=1) SHALL load the new operand with out_valid staying 1; full throughput one operand per cycle.
REQ-031 flush SHALL take priority over accept and hold: next edge out_valid=0, fwd_hit=00; output_A value is don't-care; request presented in the flush cycle is dropped.
REQ-032 stall_cnt SHALL increment by 1 each edge where out_valid && !out_ready, saturate at 2^CNT_W-1, and not wrap; flush does not clear it.

Reset
REQ-033 While rst_n=0: out_valid=0, output_A=0, fwd_hit=00, stall_cnt=0, immediately and without a clock.
REQ-034 Reset asserted mid-stall SHALL discard the held operand; first edge after release SHALL behave as empty stage (in_ready=1).

Verification
REQ-035 Reset then in_valid=1, sel=01, out_ready=1 -> next cycle out_valid=1, output_A=0x00000004, fwd_hit=00.
REQ-036 sel=00, src_reg=3, input_number=0x11, fwd_ex(en,3,0xAA), fwd_mem(en,3,0xBB) -> output_A=0xAA, fwd_hit=01; drop fwd_ex_en -> 0xBB, fwd_hit=10; src_reg=0 -> 0x11, fwd_hit=00.
REQ-037 Load 0x1234 via sel=10, hold out_ready=0 for 5 cycles while changing inputs -> output_A stays 0x1234, in_ready=0, stall_cnt=5.
REQ-038 CNT_W=2, stall 6 cycles -> stall_cnt saturates at 3.
REQ-039 out_valid=1, assert flush with in_valid=1 -> next cycle out_valid=0, fwd_hit=00, in_ready=1.
REQ-040 Back-to-back accepts with out_ready=1 over 4 cycles, values 1,2,3,4 via sel=11 -> output_A 1,2,3,4 on consecutive cycles; assert rst_n=0 mid-stream -> out_valid=0, output_A=0 without a clock edge.
